// File: rtl/like_sram_axi_pkg.sv
// Shared constants for the like-SRAM to AXI3 bridge: FSM encodings, AXI IDs and size codes.
package like_sram_axi_pkg;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_B    = 2'd2;

    localparam int ID_INST = 0;
    localparam int ID_DATA = 1;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/like_sram_wstrb.sv
// Byte-lane strobe generator: transfer size plus low address bits to a 4-bit AXI wstrb.
module like_sram_wstrb
    import like_sram_axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] wstrb
);

    // size[1] covers word and the unused code 3, which falls back to all lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wstrb[gi] = size[1]
                         | ((size == SIZE_HALF) && (addr[1] == (gi >= 2)))
                         | ((size == SIZE_BYTE) && (addr == 2'(gi)));
    end

endmodule

// File: rtl/like_sram_to_axi.sv
// Bridges the CPU inst/data like-SRAM ports onto one AXI3 master with single-beat
// transfers, at most one read and one write outstanding.
module like_sram_to_axi #(
    parameter int AXI_ID_W = 4,
    parameter int ID_INST  = like_sram_axi_pkg::ID_INST,
    parameter int ID_DATA  = like_sram_axi_pkg::ID_DATA
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [31:0]         inst_addr,
    input  logic [31:0]         inst_wdata,
    output logic [31:0]         inst_rdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic [31:0]         data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,

    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [AXI_ID_W-1:0] wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [AXI_ID_W-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    import like_sram_axi_pkg::*;

    localparam logic [AXI_ID_W-1:0] ARID_INST = ID_INST[AXI_ID_W-1:0];
    localparam logic [AXI_ID_W-1:0] XID_DATA  = ID_DATA[AXI_ID_W-1:0];

    logic [1:0]          r_state_reg, r_state_next;
    logic [1:0]          w_state_reg, w_state_next;
    logic                data_busy_reg, data_busy_next;
    logic [31:0]         araddr_reg;
    logic [1:0]          arsize_reg;
    logic [AXI_ID_W-1:0] arid_reg;
    logic [31:0]         awaddr_reg;
    logic [1:0]          awsize_reg;
    logic [31:0]         wdata_reg;
    logic                aw_done_reg, w_done_reg;

    logic rd_data_acc, rd_inst_acc, wr_acc;
    logic r_fire, b_fire, aw_fire, w_fire, rd_is_data;

    // Data reads take priority over inst reads; busy holds off a second data transfer
    assign rd_data_acc = resetn && (r_state_reg == R_IDLE) && data_req && !data_wr && !data_busy_reg;
    assign rd_inst_acc = resetn && (r_state_reg == R_IDLE) && !rd_data_acc && inst_req;
    assign wr_acc      = resetn && (w_state_reg == W_IDLE) && data_req && data_wr && !data_busy_reg;

    assign rd_is_data = (arid_reg == XID_DATA);
    assign r_fire     = rready && rvalid;
    assign b_fire     = bready && bvalid;
    assign aw_fire    = awvalid && awready;
    assign w_fire     = wvalid && wready;

    assign inst_addr_ok = rd_inst_acc;
    assign data_addr_ok = rd_data_acc || wr_acc;
    assign inst_data_ok = r_fire && !rd_is_data;
    assign data_data_ok = (r_fire && rd_is_data) || b_fire;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arvalid = resetn && (r_state_reg == R_AR);
    assign rready  = resetn && (r_state_reg == R_R);
    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arsize  = {1'b0, arsize_reg};
    assign arlen   = 4'd0;
    assign arburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awvalid = resetn && (w_state_reg == W_REQ) && !aw_done_reg;
    assign wvalid  = resetn && (w_state_reg == W_REQ) && !w_done_reg;
    assign bready  = resetn && (w_state_reg == W_B);
    assign awid    = XID_DATA;
    assign awaddr  = awaddr_reg;
    assign awsize  = {1'b0, awsize_reg};
    assign awlen   = 4'd0;
    assign awburst = BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = XID_DATA;
    assign wdata   = wdata_reg;
    assign wlast   = 1'b1;

    like_sram_wstrb u_wstrb (
        .size  (awsize_reg),
        .addr  (awaddr_reg[1:0]),
        .wstrb (wstrb)
    );

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (rd_data_acc || rd_inst_acc) r_state_next = R_AR;
            R_AR:    if (arready) r_state_next = R_R;
            R_R:     if (rvalid) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (wr_acc) w_state_next = W_REQ;
            W_REQ:   if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) w_state_next = W_B;
            W_B:     if (bvalid) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Set and clear never coincide: a clear only happens while the data port is busy
    always_comb begin
        data_busy_next = data_busy_reg;
        if (rd_data_acc || wr_acc)
            data_busy_next = 1'b1;
        else if ((r_fire && rd_is_data) || b_fire)
            data_busy_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_reg   <= R_IDLE;
            w_state_reg   <= W_IDLE;
            data_busy_reg <= 1'b0;
            araddr_reg    <= '0;
            arsize_reg    <= '0;
            arid_reg      <= '0;
            awaddr_reg    <= '0;
            awsize_reg    <= '0;
            wdata_reg     <= '0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
        end else begin
            r_state_reg   <= r_state_next;
            w_state_reg   <= w_state_next;
            data_busy_reg <= data_busy_next;
            if (rd_data_acc) begin
                araddr_reg <= data_addr;
                arsize_reg <= data_size;
                arid_reg   <= XID_DATA;
            end else if (rd_inst_acc) begin
                araddr_reg <= inst_addr;
                arsize_reg <= inst_size;
                arid_reg   <= ARID_INST;
            end
            if (wr_acc) begin
                awaddr_reg  <= data_addr;
                awsize_reg  <= data_size;
                wdata_reg   <= data_wdata;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_fire) aw_done_reg <= 1'b1;
                if (w_fire)  w_done_reg  <= 1'b1;
            end
        end
    end

    // Response IDs/status are not needed with a single read and single write in flight
    logic unused_ok;
    assign unused_ok = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

endmodule
